// File: rtl/wait_state_memory_responder.sv
// Processor-bus memory responder: wait states on nonsequential accesses, zero-wait sequential bursts,
// range/privilege abort and byte lanes. Optional abort counter: define RESPONDER_ABORT_COUNT_EN.
module wait_state_memory_responder #(
  parameter int DEPTH     = 8192,
  parameter int N_WAIT    = 1,
  parameter int PROT_BASE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        size,
  input  logic [1:0]  prot,
  input  logic [1:0]  trans,
  output logic [31:0] rdata,
  output logic        abort,
  output logic        ready
`ifdef RESPONDER_ABORT_COUNT_EN
  ,
  output logic [15:0] abort_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        write_reg;
  logic        size_reg;
  logic [31:0] last_addr_reg;
  logic        seq_valid_reg;
  logic        abort_reg;
  logic        ready_reg;
  logic [31:0] hold_reg;
  logic        rd_valid_reg;
  logic [31:0] ram_q_reg;

  logic [31:0] mem [DEPTH];

  logic          bad_access;
  logic          fast_access;
  logic          acc_now;
  logic          acc_wait_done;
  logic          ram_en;
  logic [31:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_write;
  logic          ram_size;
  logic [AW-1:0] idx;
  logic          unused_bits;

  always_comb begin
    bad_access  = (addr >= 32'(DEPTH)) ||
                  (write && !prot[1] && (addr < 32'(PROT_BASE)));
    fast_access = (N_WAIT == 0) ||
                  (trans[0] && seq_valid_reg && (addr == last_addr_reg + 32'd1));
    // Gating with reset keeps an asserted reset from letting a bus request reach the RAM.
    acc_now       = (state_reg == IDLE) && trans[1] && !bad_access && fast_access && !reset;
    acc_wait_done = (state_reg == WAIT) && (cnt_reg <= 4'd1) && !reset;
    ram_en        = acc_now || acc_wait_done;
    ram_addr      = acc_now ? addr  : addr_reg;
    ram_wdata     = acc_now ? wdata : wdata_reg;
    ram_write     = acc_now ? write : write_reg;
    ram_size      = acc_now ? size  : size_reg;
    idx           = ram_addr[AW-1:0];
    unused_bits   = &{1'b0, prot[0], ram_addr[31:AW]};
  end

  // Block RAM: no reset, byte lane 0 always written, upper lanes only on word writes.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_write) begin
        mem[idx][7:0] <= ram_wdata[7:0];
        if (ram_size)
          mem[idx][31:8] <= ram_wdata[31:8];
      end else begin
        ram_q_reg <= ram_size ? mem[idx] : {24'b0, mem[idx][7:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      write_reg     <= 1'b0;
      size_reg      <= 1'b0;
      last_addr_reg <= 32'd0;
      seq_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
      ready_reg     <= 1'b1;
      hold_reg      <= 32'd0;
      rd_valid_reg  <= 1'b0;
    end else begin
      abort_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      if (rd_valid_reg)
        hold_reg <= ram_q_reg;
      case (state_reg)
        IDLE: begin
          if (trans[1]) begin
            if (bad_access) begin
              abort_reg     <= 1'b1;
              seq_valid_reg <= 1'b0;
              hold_reg      <= 32'd0;
            end else if (fast_access) begin
              last_addr_reg <= addr;
              seq_valid_reg <= 1'b1;
              rd_valid_reg  <= !write;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(N_WAIT);
              ready_reg <= 1'b0;
              addr_reg  <= addr;
              wdata_reg <= wdata;
              write_reg <= write;
              size_reg  <= size;
            end
          end
        end
        WAIT: begin
          if (cnt_reg <= 4'd1) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            last_addr_reg <= addr_reg;
            seq_valid_reg <= 1'b1;
            rd_valid_reg  <= !write_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Freshly read data is forwarded straight from the RAM register; afterwards the held copy drives rdata.
  assign rdata = rd_valid_reg ? ram_q_reg : hold_reg;
  assign abort = abort_reg;
  assign ready = ready_reg;

`ifdef RESPONDER_ABORT_COUNT_EN
  logic [15:0] abort_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      abort_count_reg <= 16'd0;
    else if (abort_reg && abort_count_reg != 16'hFFFF)
      abort_count_reg <= abort_count_reg + 16'd1;
  end

  assign abort_count = abort_count_reg;
`endif

endmodule

// File: tb/tb_wait_state_memory_responder.sv
// Randomized and directed bench for wait_state_memory_responder against a transaction-level memory model.
module tb_wait_state_memory_responder;

  localparam int DEPTH     = 8192;
  localparam int NW        = 2;
  localparam int PROT_BASE = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic        size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] rdata;
  logic        abort;
  logic        ready;
`ifdef RESPONDER_ABORT_COUNT_EN
  logic [15:0] abort_count;
`endif

  wait_state_memory_responder #(.DEPTH(DEPTH), .N_WAIT(NW), .PROT_BASE(PROT_BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write(write), .size(size),
    .prot(prot), .trans(trans), .rdata(rdata), .abort(abort), .ready(ready)
`ifdef RESPONDER_ABORT_COUNT_EN
    , .abort_count(abort_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_last   = 32'd0;
  logic        m_seq    = 1'b0;
  logic [31:0] m_rdata  = 32'd0;
  int          m_aborts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One bus transaction: predict waits/abort/rdata from the rules, then drive and observe.
  task automatic access(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] wd,
                        input logic wr, input logic sz, input logic [1:0] pr, input string tag);
    logic e_abort;
    int   e_waits;
    int   waits;
    e_abort = (a >= DEPTH) || (wr && !pr[1] && a < PROT_BASE);
    if (e_abort)
      e_waits = 0;
    else if (tr == 2'b11 && m_seq && a == m_last + 32'd1)
      e_waits = 0;
    else
      e_waits = NW;
    if (e_abort) begin
      m_seq   = 1'b0;
      m_rdata = 32'd0;
      m_aborts++;
    end else begin
      if (wr) begin
        if (sz) m_mem[a] = wd;
        else    m_mem[a] = {m_mem[a][31:8], wd[7:0]};
      end else begin
        m_rdata = sz ? m_mem[a] : {24'b0, m_mem[a][7:0]};
      end
      m_last = a;
      m_seq  = 1'b1;
    end
    addr = a; wdata = wd; write = wr; size = sz; prot = pr; trans = tr;
    @(posedge clk); #1;
    trans = 2'b00;
    waits = 0;
    while (ready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    $display("txn %s tr=%b a=%0d wr=%b sz=%b pr=%b waits=%0d abort=%b rdata=%h",
             tag, tr, a, wr, sz, pr, waits, abort, rdata);
    chk({tag, ".waits"}, 32'(waits), 32'(e_waits));
    chk({tag, ".abort"}, {31'b0, abort}, {31'b0, e_abort});
    chk({tag, ".rdata"}, rdata, m_rdata);
  endtask

  task automatic idle_cycle(input string tag);
    trans = 2'b00;
    @(posedge clk); #1;
    chk({tag, ".abort"}, {31'b0, abort}, 32'd0);
    chk({tag, ".rdata"}, rdata, m_rdata);
    chk({tag, ".ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  tr;
    logic [1:0]  pr;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    reset = 1'b1; addr = 0; wdata = 0; write = 0; size = 0; prot = 0; trans = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", {31'b0, ready}, 32'd1);
    chk("reset.abort", {31'b0, abort}, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    reset = 1'b0;

    // Establish known RAM contents everywhere the bench reads.
    access(2'b10, 32'd16, 32'd0, 1'b1, 1'b1, 2'b10, "init16");
    for (int i = 300; i <= 305; i++) access(2'b10, 32'(i), 32'd0, 1'b1, 1'b1, 2'b10, "init");
    access(2'b10, 32'd500, 32'd0, 1'b1, 1'b1, 2'b10, "init500");
    access(2'b10, 32'd501, 32'd0, 1'b1, 1'b1, 2'b10, "init501");
    for (int i = 600; i < 640; i++) access(2'b10, 32'(i), 32'd0, 1'b1, 1'b1, 2'b10, "init");

    access(2'b10, 32'd300, 32'hDEADBEEF, 1'b1, 1'b1, 2'b10, "wr300");
    access(2'b10, 32'd300, 32'd0, 1'b0, 1'b1, 2'b10, "rd300");

    access(2'b10, 32'd300, 32'd0, 1'b0, 1'b1, 2'b10, "burst300");
    access(2'b11, 32'd301, 32'd0, 1'b0, 1'b1, 2'b10, "burst301");
    access(2'b11, 32'd302, 32'd0, 1'b0, 1'b1, 2'b10, "burst302");
    access(2'b11, 32'd305, 32'd0, 1'b0, 1'b1, 2'b10, "jump305");

    access(2'b10, 32'd16, 32'h11, 1'b1, 1'b1, 2'b00, "userwr16");
    idle_cycle("after_abort");
    access(2'b10, 32'd16, 32'd0, 1'b0, 1'b1, 2'b10, "rd16_untouched");
    access(2'b10, 32'd16, 32'h11, 1'b1, 1'b1, 2'b10, "privwr16");
    access(2'b10, 32'd16, 32'd0, 1'b0, 1'b1, 2'b00, "rd16");
    access(2'b10, 32'd8192, 32'd0, 1'b0, 1'b1, 2'b10, "rd8192");

    access(2'b10, 32'd400, 32'hAABBCCDD, 1'b1, 1'b1, 2'b10, "init400");
    access(2'b10, 32'd400, 32'h12345678, 1'b1, 1'b0, 2'b10, "bytewr400");
    access(2'b10, 32'd400, 32'd0, 1'b0, 1'b0, 2'b10, "byterd400");
    access(2'b10, 32'd400, 32'd0, 1'b0, 1'b1, 2'b10, "wordrd400");
    chk("model400", m_mem[400], 32'hAABBCC78);

    for (int n = 0; n < 80; n++) begin
      int r;
      r  = int'($urandom_range(0, 9));
      tr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
      pr = 2'($urandom_range(0, 3));
      if (r == 0) begin
        a = 32'(DEPTH) + 32'($urandom_range(0, 100));
        access(tr, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pr, "rnd_range");
      end else if (r == 1) begin
        a = 32'($urandom_range(0, PROT_BASE - 1));
        access(tr, a, $urandom, 1'b1, 1'($urandom_range(0, 1)), {1'b0, pr[0]}, "rnd_priv");
      end else begin
        if ($urandom_range(0, 1) != 0 && m_last + 32'd1 >= 32'd600 && m_last + 32'd1 < 32'd640)
          a = m_last + 32'd1;
        else
          a = 32'd600 + 32'($urandom_range(0, 39));
        access(tr, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pr, "rnd");
      end
      if ($urandom_range(0, 7) == 0) idle_cycle("rnd_idle");
    end

`ifdef RESPONDER_ABORT_COUNT_EN
    chk("abort_count", {16'b0, abort_count}, 32'(m_aborts));
`endif

    // Reset during the first wait cycle of a write to 500.
    addr = 32'd500; wdata = 32'h5; write = 1'b1; size = 1'b1; prot = 2'b10; trans = 2'b10;
    @(posedge clk); #1;
    trans = 2'b00;
    chk("midrst.waiting", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    #1;
    m_seq = 1'b0;
    m_rdata = 32'd0;
    chk("midrst.ready", {31'b0, ready}, 32'd1);
    chk("midrst.abort", {31'b0, abort}, 32'd0);
    chk("midrst.rdata", rdata, 32'd0);
`ifdef RESPONDER_ABORT_COUNT_EN
    chk("midrst.abort_count", {16'b0, abort_count}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    access(2'b11, 32'd501, 32'd0, 1'b0, 1'b1, 2'b10, "post_rst501");
    access(2'b10, 32'd500, 32'd0, 1'b0, 1'b1, 2'b10, "rd500_unchanged");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wait_state_memory_responder.md
Name: wait_state_memory_responder

Overview:
- Bus responder on the processor memory interface (addr, wdata, rdata, abort, write, size, prot, trans); replaces the zero-wait memory model.
- Adds a configurable wait-state generator, sequential-burst detection, address-range and privilege abort checking, and byte-sized accesses.
- Sits between the processor bus and a word-indexed on-chip RAM; `addr` is a word index.

Parameters:
- DEPTH, 8192, number of 32-bit words; valid addr range 0..DEPTH-1.
- N_WAIT, 1, wait cycles inserted on a nonsequential access (0..15).
- PROT_BASE, 256, lowest word index writable in user mode.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  word index of access.
- wdata  input  32  write data.
- write  input  1  1 = write, 0 = read.
- size  input  1  1 = word, 0 = byte (bits [7:0] only).
- prot  input  2  prot[1] = privileged, prot[0] = opcode fetch (ignored).
- trans  input  2  00 idle, 01 coprocessor/busy, 10 nonsequential, 11 sequential.
- rdata  output  32  read data.
- abort  output  1  access aborted.
- ready  output  1  1 = responder accepting / data valid; 0 = wait.

Behaviour:
- Reset (async, any state): state=IDLE; rdata=0; abort=0; ready=1; seq_valid=0; pending access discarded; RAM contents untouched. RAM powers up all-zero.
- States:
  - IDLE: ready=1.
  - WAIT: ready=0, wait counter running.
  - Returns to IDLE after the access completes.
- Request accepted at a rising edge only when state=IDLE and trans[1]=1. Captured fields: addr, wdata, write, size, prot. trans 00/01 in IDLE: no access, rdata holds, abort=0.
- Abort check, at acceptance:
  - Abort when addr >= DEPTH, or when write=1, prot[1]=0 and addr < PROT_BASE.
  - Result: no RAM effect; cycle T+1 has abort=1, rdata=0, ready=1; seq_valid cleared.
  - abort is high for exactly one cycle per aborted access.
- Zero-wait case: trans=11, seq_valid=1 and addr == last_addr+1 (32-bit wrap), or N_WAIT=0.
  - Access is performed at acceptance edge T.
  - Read data appears on rdata in cycle T+1; ready stays 1, so back-to-back bursts run one word per cycle.
- Wait case (otherwise, including trans=10, or 11 to a non-consecutive address):
  - Enter WAIT with counter=N_WAIT; ready=0 during cycles T+1..T+N_WAIT.
  - At the edge ending cycle T+N_WAIT, the RAM access is performed and the state returns to IDLE.
  - Read data is valid with ready=1 in cycle T+N_WAIT+1.
  - Bus inputs are ignored while in WAIT.
- Successful access: last_addr=addr, seq_valid=1.
- Byte writes (size=0) update bits [7:0] only; other bits are preserved. Byte reads return {24'b0, mem[7:0]}.
- rdata holds its last value after writes and idle cycles.

Optional Feature:
- Macro RESPONDER_ABORT_COUNT_EN.
- Defined:
  - Extra output abort_count (16 bits).
  - Reset value 0; increments by 1 on each aborted access; saturates at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use N_WAIT=2, DEPTH=8192, PROT_BASE=256.
- Wait-state read/write: nonsequential write of 0xDEADBEEF to addr 300, prot=2'b10 -> ready=0 for 2 cycles, ready=1 at T+3. Then nonsequential read of 300 -> ready=0 for 2 cycles, rdata=0xDEADBEEF with ready=1 at T+3.
- Sequential burst: reads at 300 (trans=10), 301, 302 (trans=11) -> 2 waits on the first access only, 0 waits on the next two. Then trans=11 to addr 305 -> 2 waits.
- Privilege check:
  - User write (prot=2'b00) of 0x11 to addr 16 -> abort=1 for one cycle at T+1, rdata=0, no wait; mem[16] stays 0.
  - Same write with prot=2'b10 -> completes; a read of 16 returns 0x11.
  - Read of addr 8192 -> abort=1, rdata=0.
- Byte access: mem[400]=0xAABBCCDD; byte write of wdata=0x12345678 -> mem[400]=0xAABBCC78; byte read -> 0x00000078; word read -> 0xAABBCC78.
- Reset mid-access: assert reset during the 1st wait cycle of a write of 0x5 to addr 500 -> immediately ready=1, abort=0, rdata=0; mem[500] unchanged. After release, a trans=11 to 501 incurs 2 waits (seq_valid cleared).
- With RESPONDER_ABORT_COUNT_EN: 3 aborted accesses -> abort_count=3; reset -> 0.
